// File: rtl/bullet_pool_if.sv
// Bus between the game/scan logic (master) and the bullet pool (slave).
// Carries frame timing, scan position, ship state, asteroid coincidence and bullet outputs.
interface bullet_pool_if #(
    parameter int ASTEROID_COUNT = 10,
    parameter int MAX_BULLETS    = 4,
    parameter int SCREEN_CORDW   = 16,
    parameter int COLR_BITS      = 4
);
    logic                                 frame;
    logic signed [SCREEN_CORDW-1:0]       screen_x;
    logic signed [SCREEN_CORDW-1:0]       screen_y;
    logic                                 fire;
    logic signed [SCREEN_CORDW-1:0]       ship_x;
    logic signed [SCREEN_CORDW-1:0]       ship_y;
    logic [ASTEROID_COUNT-1:0]            asteroid_drawing;
    logic [ASTEROID_COUNT-1:0]            shot;
    logic                                 drawing;
    logic [COLR_BITS-1:0]                 pixel;
    logic [$clog2(MAX_BULLETS+1)-1:0]     active_count;

    modport master (
        output frame, screen_x, screen_y, fire, ship_x, ship_y, asteroid_drawing,
        input  shot, drawing, pixel, active_count
    );

    modport slave (
        input  frame, screen_x, screen_y, fire, ship_x, ship_y, asteroid_drawing,
        output shot, drawing, pixel, active_count
    );
endinterface

// File: rtl/bullet_pool.sv
// Fixed pool of bullet slots: spawn on fire with cooldown, move up once per frame, detect asteroid hits.
// Optional macro BULLET_PIERCE_EN: hit bullets keep flying instead of being consumed.
module bullet_pool #(
    parameter int ASTEROID_COUNT = 10,
    parameter int MAX_BULLETS    = 4,
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int SCREEN_CORDW   = 16,
    parameter int COLR_BITS      = 4,
    parameter int BULLET_W       = 4,
    parameter int BULLET_H       = 12,
    parameter int SHIP_W         = 80,
    parameter int BULLET_SPEED   = 8,
    parameter int COOLDOWN       = 8,
    parameter logic [COLR_BITS-1:0] BULLET_COLR = 4'hE
) (
    input  logic          clk,
    input  logic          rst,
    bullet_pool_if.slave  bus
);
    localparam int CD_W  = $clog2(COOLDOWN + 2);
    localparam int CNT_W = $clog2(MAX_BULLETS + 1);

    localparam logic signed [SCREEN_CORDW-1:0] BW_S     = SCREEN_CORDW'(BULLET_W);
    localparam logic signed [SCREEN_CORDW-1:0] BH_S     = SCREEN_CORDW'(BULLET_H);
    localparam logic signed [SCREEN_CORDW-1:0] SPEED_S  = SCREEN_CORDW'(BULLET_SPEED);
    localparam logic signed [SCREEN_CORDW-1:0] SPAWN_DX = SCREEN_CORDW'(SHIP_W / 2 - BULLET_W / 2);
    localparam logic signed [SCREEN_CORDW-1:0] ZERO_S   = '0;
    localparam logic [CD_W-1:0]                CD_RELOAD = CD_W'(COOLDOWN);

    // Coordinates must hold the full visible range plus a sign bit.
    if (SCREEN_CORDW < $clog2(H_RES + 1) + 1 || SCREEN_CORDW < $clog2(V_RES + 1) + 1) begin : g_cordw_check
        $error("SCREEN_CORDW too narrow for H_RES/V_RES");
    end

    logic [MAX_BULLETS-1:0]           r_act;
    logic [MAX_BULLETS-1:0]           r_hit;
    logic signed [SCREEN_CORDW-1:0]   r_bx [MAX_BULLETS];
    logic signed [SCREEN_CORDW-1:0]   r_by [MAX_BULLETS];
    logic [CD_W-1:0]                  r_cd;
    logic [ASTEROID_COUNT-1:0]        r_shot;
    logic [CNT_W-1:0]                 r_cnt;

    logic [MAX_BULLETS-1:0]           w_cover;
    logic                             w_any_cover;
    logic [MAX_BULLETS-1:0]           w_act_n;
    logic [MAX_BULLETS-1:0]           w_hit_n;
    logic signed [SCREEN_CORDW-1:0]   w_bx_n [MAX_BULLETS];
    logic signed [SCREEN_CORDW-1:0]   w_by_n [MAX_BULLETS];
    logic [CD_W-1:0]                  w_cd_n;
    logic [ASTEROID_COUNT-1:0]        w_shot_n;
    logic [CNT_W-1:0]                 w_cnt_n;
    logic                             w_spawned;

    always_comb begin
        w_cover = '0;
        for (int j = 0; j < MAX_BULLETS; j++) begin
            w_cover[j] = r_act[j]
                       && (bus.screen_x >= r_bx[j]) && (bus.screen_x < r_bx[j] + BW_S)
                       && (bus.screen_y >= r_by[j]) && (bus.screen_y < r_by[j] + BH_S);
        end
    end

    assign w_any_cover = |w_cover;

    // Frame edge runs consume/move/expire/cooldown/spawn; other edges only collect hits.
    always_comb begin
        w_act_n   = r_act;
        w_hit_n   = r_hit;
        w_bx_n    = r_bx;
        w_by_n    = r_by;
        w_cd_n    = r_cd;
        w_shot_n  = r_shot;
        w_spawned = 1'b0;
        if (bus.frame) begin
            w_shot_n = '0;
            for (int j = 0; j < MAX_BULLETS; j++) begin
                if (w_hit_n[j]) begin
`ifdef BULLET_PIERCE_EN
                    w_hit_n[j] = 1'b0;
`else
                    w_act_n[j] = 1'b0;
                    w_hit_n[j] = 1'b0;
`endif
                end
                if (w_act_n[j]) begin
                    w_by_n[j] = r_by[j] - SPEED_S;
                    if (w_by_n[j] + BH_S <= ZERO_S) begin
                        w_act_n[j] = 1'b0;
                    end
                end
            end
            if (r_cd != '0) begin
                w_cd_n = r_cd - CD_W'(1);
            end
            for (int j = 0; j < MAX_BULLETS; j++) begin
                if (bus.fire && (r_cd == '0) && !w_spawned && !w_act_n[j]) begin
                    w_act_n[j] = 1'b1;
                    w_hit_n[j] = 1'b0;
                    w_bx_n[j]  = bus.ship_x + SPAWN_DX;
                    w_by_n[j]  = bus.ship_y - BH_S;
                    w_spawned  = 1'b1;
                end
            end
            if (w_spawned) begin
                w_cd_n = CD_RELOAD;
            end
        end else begin
            for (int i = 0; i < ASTEROID_COUNT; i++) begin
                if (bus.asteroid_drawing[i] && w_any_cover) begin
                    w_shot_n[i] = 1'b1;
                end
            end
            for (int j = 0; j < MAX_BULLETS; j++) begin
                if (w_cover[j] && (|bus.asteroid_drawing)) begin
                    w_hit_n[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cnt_n = '0;
        for (int j = 0; j < MAX_BULLETS; j++) begin
            w_cnt_n = w_cnt_n + CNT_W'(w_act_n[j]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act  <= '0;
            r_hit  <= '0;
            r_cd   <= '0;
            r_shot <= '0;
            r_cnt  <= '0;
            for (int j = 0; j < MAX_BULLETS; j++) begin
                r_bx[j] <= '0;
                r_by[j] <= '0;
            end
        end else begin
            r_act  <= w_act_n;
            r_hit  <= w_hit_n;
            r_cd   <= w_cd_n;
            r_shot <= w_shot_n;
            r_cnt  <= w_cnt_n;
            for (int j = 0; j < MAX_BULLETS; j++) begin
                r_bx[j] <= w_bx_n[j];
                r_by[j] <= w_by_n[j];
            end
        end
    end

    assign bus.shot         = r_shot;
    assign bus.active_count = r_cnt;
    assign bus.drawing      = w_any_cover;
    assign bus.pixel        = w_any_cover ? BULLET_COLR : '0;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: default instance (COOLDOWN=8) and a COOLDOWN=0 instance.
module tb_bullet_pool;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    bullet_pool_if ifa ();
    bullet_pool_if ifb ();

    bullet_pool u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    bullet_pool #(.COOLDOWN(0)) u_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_a(input logic f);
        @(negedge clk);
        ifa.frame = 1'b1;
        ifa.fire  = f;
        tick();
        ifa.frame = 1'b0;
        ifa.fire  = 1'b0;
    endtask

    task automatic frame_b(input logic f);
        @(negedge clk);
        ifb.frame = 1'b1;
        ifb.fire  = f;
        tick();
        ifb.frame = 1'b0;
        ifb.fire  = 1'b0;
    endtask

    task automatic probe_a(input string tag, input int x, input int y, input logic exp);
        ifa.screen_x = 16'(x);
        ifa.screen_y = 16'(y);
        #1;
        chk(tag, ifa.drawing, exp);
    endtask

    task automatic probe_b(input string tag, input int x, input int y, input logic exp);
        ifb.screen_x = 16'(x);
        ifb.screen_y = 16'(y);
        #1;
        chk(tag, ifb.drawing, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.frame = 0; ifa.fire = 0; ifa.screen_x = 0; ifa.screen_y = 0;
        ifa.ship_x = 16'sd280; ifa.ship_y = 16'sd400; ifa.asteroid_drawing = '0;
        ifb.frame = 0; ifb.fire = 0; ifb.screen_x = 0; ifb.screen_y = 0;
        ifb.ship_x = 16'sd100; ifb.ship_y = 16'sd50; ifb.asteroid_drawing = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", ifa.active_count, 0);
        chk("rst_shot", ifa.shot, 0);
        chk("rst_draw", ifa.drawing, 0);
        chk("rst_pixel", ifa.pixel, 0);

        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // First fire after reset: bullet at (318,388), 4x12
        frame_a(1'b1);
        chk("spawn_cnt", ifa.active_count, 1);
        probe_a("spawn_tl", 318, 388, 1'b1);
        chk("spawn_pixel", ifa.pixel, 4'hE);
        probe_a("spawn_left", 317, 388, 1'b0);
        probe_a("spawn_right", 322, 388, 1'b0);
        probe_a("spawn_br", 321, 399, 1'b1);
        probe_a("spawn_below", 321, 400, 1'b0);
        probe_a("spawn_above", 318, 387, 1'b0);
        chk("gap_pixel", ifa.pixel, 0);

        // fire held for frames 1..19: spawns only at 9 and 18
        for (int k = 1; k < 20; k++) begin
            frame_a(1'b1);
            if (k == 1) begin
                probe_a("move1_top", 318, 380, 1'b1);
                probe_a("move1_above", 318, 379, 1'b0);
                probe_a("move1_bot", 318, 391, 1'b1);
                probe_a("move1_below", 318, 392, 1'b0);
            end
            if (k == 8)  chk("cd_f8_cnt", ifa.active_count, 1);
            if (k == 9)  chk("cd_f9_cnt", ifa.active_count, 2);
            if (k == 17) chk("cd_f17_cnt", ifa.active_count, 2);
            if (k == 18) chk("cd_f18_cnt", ifa.active_count, 3);
        end
        chk("f19_cnt", ifa.active_count, 3);
        probe_a("b0_f19_top", 318, 236, 1'b1);
        probe_a("b0_f19_above", 318, 235, 1'b0);
        probe_a("b0_f19_bot", 318, 247, 1'b1);
        probe_a("b1_f19_top", 318, 308, 1'b1);
        probe_a("b1_f19_above", 318, 307, 1'b0);

        // Frames 20..24: bullet0 reaches y=196, bullet1 268, bullet2 340
        repeat (5) frame_a(1'b0);

        @(negedge clk);
        ifa.screen_x = 16'sd320;
        ifa.screen_y = 16'sd200;
        ifa.asteroid_drawing = 10'b00_0000_1000;
        #1;
        chk("hit_cover", ifa.drawing, 1);
        tick();
        chk("shot_set", ifa.shot, 10'h008);
        @(negedge clk);
        ifa.asteroid_drawing = '0;
        ifa.screen_x = 0;
        ifa.screen_y = 0;
        tick();
        chk("shot_hold", ifa.shot, 10'h008);
        frame_a(1'b0);
        chk("shot_clear", ifa.shot, 0);
        chk("consume_cnt", ifa.active_count, 2);
        probe_a("consumed_gone", 320, 190, 1'b0);
        probe_a("b1_at_260", 318, 260, 1'b1);

        // Clear on the frame edge beats a set on that same edge
        @(negedge clk);
        ifa.screen_x = 16'sd318;
        ifa.screen_y = 16'sd260;
        ifa.asteroid_drawing = 10'b00_0010_0000;
        tick();
        chk("shot_b5", ifa.shot, 10'h020);
        @(negedge clk);
        ifa.frame = 1'b1;
        tick();
        ifa.frame = 1'b0;
        ifa.asteroid_drawing = '0;
        chk("clear_prec", ifa.shot, 0);
        chk("prec_cnt", ifa.active_count, 1);

        // Coincidence during frame=1 is ignored (bullet2 at 324)
        @(negedge clk);
        ifa.screen_x = 16'sd318;
        ifa.screen_y = 16'sd324;
        ifa.asteroid_drawing = 10'b00_0000_0010;
        ifa.frame = 1'b1;
        tick();
        ifa.frame = 1'b0;
        ifa.asteroid_drawing = '0;
        chk("ign_shot", ifa.shot, 0);
        frame_a(1'b0);
        chk("ign_keep", ifa.active_count, 1);

        // bullet2 at 308 -> 38 frames to y=4
        repeat (38) frame_a(1'b0);
        probe_a("y4_top", 318, 4, 1'b1);
        probe_a("y4_above", 318, 3, 1'b0);
        chk("y4_cnt", ifa.active_count, 1);
        frame_a(1'b0);
        chk("ym4_cnt", ifa.active_count, 1);
        probe_a("ym4_row0", 318, 0, 1'b1);
        probe_a("ym4_row7", 318, 7, 1'b1);
        probe_a("ym4_row8", 318, 8, 1'b0);
        frame_a(1'b0);
        chk("ym12_cnt", ifa.active_count, 0);
        probe_a("ym12_gone", 318, 0, 1'b0);

        // COOLDOWN=0 instance: fill the pool, extra fire dropped
        for (int k = 0; k < 5; k++) begin
            frame_b(1'b1);
            chk("fill_cnt", ifb.active_count, (k < 4) ? k + 1 : 4);
        end
        probe_b("full_s0", 138, 6, 1'b1);
        probe_b("full_s3_bot", 138, 41, 1'b1);
        probe_b("full_none", 138, 42, 1'b0);

        // Slot freed by a hit is reused by the same frame's spawn
        @(negedge clk);
        ifb.screen_x = 16'sd138;
        ifb.screen_y = 16'sd6;
        ifb.asteroid_drawing = 10'b00_0000_0001;
        tick();
        chk("b_shot", ifb.shot, 10'h001);
        @(negedge clk);
        ifb.asteroid_drawing = '0;
        frame_b(1'b1);
        chk("reuse_shot", ifb.shot, 0);
        chk("reuse_cnt", ifb.active_count, 4);
        probe_b("reuse_spawn", 138, 38, 1'b1);
        probe_b("reuse_bot", 138, 49, 1'b1);
        probe_b("reuse_below", 138, 50, 1'b0);

        // Pending hit, then asynchronous reset mid-scan
        @(negedge clk);
        ifb.screen_x = 16'sd138;
        ifb.screen_y = 16'sd6;
        ifb.asteroid_drawing = 10'b00_0000_0001;
        tick();
        chk("pend_shot", ifb.shot, 10'h001);
        #3;
        rst_b = 1'b1;
        #1;
        chk("arst_shot", ifb.shot, 0);
        chk("arst_cnt", ifb.active_count, 0);
        chk("arst_draw", ifb.drawing, 0);
        chk("arst_pixel", ifb.pixel, 0);
        @(negedge clk);
        ifb.asteroid_drawing = '0;
        rst_b = 1'b0;
        frame_b(1'b1);
        chk("post_rst_cnt", ifb.active_count, 1);
        chk("post_rst_shot", ifb.shot, 0);
        probe_b("post_rst_spawn", 138, 38, 1'b1);
        probe_b("post_rst_above", 138, 37, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 SHALL have parameter ASTEROID_COUNT, default 10, number of asteroid targets.
REQ-002 SHALL have parameter MAX_BULLETS, default 4, number of bullet slots.
REQ-003 SHALL have parameters H_RES 640, V_RES 480, SCREEN_CORDW 16, COLR_BITS 4, with the usual screen and colour meaning.
REQ-004 SHALL have parameters BULLET_W 4, BULLET_H 12, SHIP_W 80, BULLET_SPEED 8 (px/frame), COOLDOWN 8 (frames), BULLET_COLR 4'hE.
REQ-005 clk  in  1  pixel clock; the only clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 frame  in  1  one-clk pulse, once per frame, synchronous to clk.
REQ-008 screen_x, screen_y  in  SCREEN_CORDW signed  current scan position.
REQ-009 fire  in  1  fire request, level-sampled at frame.
REQ-010 ship_x, ship_y  in  SCREEN_CORDW signed  ship top-left corner.
REQ-011 asteroid_drawing  in  ASTEROID_COUNT  per-asteroid drawing flag at the current scan position.
REQ-012 shot  out  ASTEROID_COUNT  per-asteroid hit flag; asteroid i samples it on the rising edge of frame.
REQ-013 drawing  out  1  a bullet covers the current scan position.
REQ-014 pixel  out  COLR_BITS  BULLET_COLR when drawing is 1, else 0.
REQ-015 active_count  out  $clog2(MAX_BULLETS+1)  number of active slots.

Function
REQ-016 Each slot SHALL hold: active, hit, bx and by (signed SCREEN_CORDW).
REQ-017 Slot j covers (x,y) iff it is active, bx<=x<bx+BULLET_W and by<=y<by+BULLET_H; all comparisons signed.
REQ-018 drawing and pixel SHALL be combinational from the registered slot state and screen_x/screen_y (zero latency), so they stay aligned with asteroid_drawing.
REQ-019 On a clk edge with frame=0, shot[i] SHALL set if asteroid_drawing[i] is 1 and any slot covers the scan position; every covering slot's hit flag SHALL set.
REQ-020 shot[i] SHALL hold until the clk edge where frame=1, then clear to 0; a clear on that edge takes precedence over any set.
REQ-021 Coincidences sampled while frame=1 SHALL be ignored.
REQ-022 On the frame=1 edge the block SHALL apply these steps in order, in one cycle.
REQ-023 Step a: every slot with hit=1 SHALL become inactive and its hit flag SHALL clear.
REQ-024 Step b: every active slot SHALL update by <= by-BULLET_SPEED.
REQ-025 Step c: a slot whose new by+BULLET_H <= 0 SHALL become inactive.
REQ-026 Step d: cooldown SHALL decrement if it is nonzero.
REQ-027 Step e: if fire=1, the pre-decrement cooldown was 0 and a slot is free after steps a-c, the lowest-index free slot SHALL spawn.
REQ-028 A spawned slot SHALL get bx=ship_x+SHIP_W/2-BULLET_W/2, by=ship_y-BULLET_H and hit=0, and SHALL NOT move in that frame; cooldown SHALL reload to COOLDOWN.
REQ-029 A fire request with all slots full, or with cooldown nonzero, SHALL be dropped (not queued), and cooldown SHALL NOT reload.
REQ-030 A slot freed in steps a-c SHALL be reusable in step e of the same frame.
REQ-031 active_count SHALL be a registered population count of the active flags, updated on the same edge as the flags.
REQ-032 Width rule: all position arithmetic SHALL be signed SCREEN_CORDW, with parameters cast to signed, so negative y is valid.

Reset
REQ-033 While rst=1, asynchronously: all slots inactive, all hit flags 0, bx/by 0, cooldown 0, shot 0, active_count 0.
REQ-034 While rst=1, drawing=0 and pixel=0 as a result.
REQ-035 Reset asserted mid-frame SHALL discard pending hits; the first frame after release SHALL accept fire immediately.

Configuration
REQ-036 Macro BULLET_PIERCE_EN: when defined, step a SHALL clear hit flags without deactivating slots, so bullets pass through asteroids; shot behaviour is unchanged.
REQ-037 When BULLET_PIERCE_EN is undefined, hit bullets SHALL be consumed as in REQ-023.

Verification
REQ-038 Reset release, then fire=1 at frame with ship=(280,400) -> slot0 active, bx=318, by=388, active_count=1, cooldown=8.
REQ-039 fire held high for 20 frames -> spawns at frames 0, 9 and 18 only; each bullet's by drops by 8 per frame.
REQ-040 Bullet at by=4 at a frame -> by=-4 (still active since -4+12>0); next frame by=-12 -> inactive, active_count decrements.
REQ-041 Bullet covering (320,200) while asteroid_drawing[3]=1 there -> shot=0b0000001000 until the next frame edge, then 0.
REQ-042 Same hit -> bullet inactive after that frame; with BULLET_PIERCE_EN defined -> bullet remains active and continues moving.
REQ-043 MAX_BULLETS=4, COOLDOWN=0, fire held high -> 4 active and further fires dropped; rst pulse mid-scan -> everything 0 and the next frame spawns into slot0.
